// File: rtl/relu_maxpool_stage.sv
// ReLU on the registered batch-norm stream, optionally followed by 2x2 stride-2 max pooling.
// Raster-order pixels, one per strobe. A half-width line buffer carries pair maxima from even rows.
module relu_maxpool_stage #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int MAX_POOL     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         relu_en_relu,
    input  logic signed [DATA_WIDTH-1:0] bn_output_relu,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         frame_done
);
    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam bit ODD_W = (IMAGE_WIDTH % 2) != 0;
    localparam bit ODD_H = (IMAGE_HEIGHT % 2) != 0;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] w_relu;
    logic                  w_col_last;
    logic                  w_row_last;

    assign w_relu     = bn_output_relu[DATA_WIDTH-1] ? '0 : bn_output_relu;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (relu_en_relu) begin
                r_frame_done <= w_col_last && w_row_last;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    if (MAX_POOL == 0) begin : g_pass
        always_ff @(posedge clk) begin
            if (rst) begin
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= relu_en_relu;
                if (relu_en_relu)
                    r_out_data <= w_relu;
            end
        end
    end else begin : g_pool
        localparam int LB_DEPTH = IMAGE_WIDTH / 2;
        localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

        logic [DATA_WIDTH-1:0] r_linebuf [LB_DEPTH];
        logic [DATA_WIDTH-1:0] r_hreg;
        logic [LBW-1:0]        w_lb_idx;
        logic                  w_col_paired;
        logic                  w_row_paired;
        logic [DATA_WIDTH-1:0] w_hmax;
        logic [DATA_WIDTH-1:0] w_lb_rd;
        logic [DATA_WIDTH-1:0] w_wmax;

        // Trailing odd column/row has no partner and is simply consumed.
        assign w_col_paired = !(ODD_W && w_col_last);
        assign w_row_paired = !(ODD_H && w_row_last);
        assign w_lb_idx     = LBW'(r_col >> 1);
        assign w_hmax       = (r_hreg > w_relu) ? r_hreg : w_relu;
        assign w_lb_rd      = r_linebuf[w_lb_idx];
        assign w_wmax       = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;

        // Not reset: every entry is written by an even row before the odd row reads it.
        always_ff @(posedge clk) begin
            if (!rst && relu_en_relu && !r_row[0] && r_col[0] && w_row_paired)
                r_linebuf[w_lb_idx] <= w_hmax;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_hreg      <= '0;
                r_out_data  <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= 1'b0;
                if (relu_en_relu) begin
                    if (!r_col[0] && w_col_paired && w_row_paired)
                        r_hreg <= w_relu;
                    if (r_row[0] && r_col[0]) begin
                        r_out_data  <= w_wmax;
                        r_out_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_relu_maxpool_stage.sv
// Directed and randomized checks of relu_maxpool_stage against a window-level reference model.
module tb_relu_maxpool_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               s [4];
    logic signed [15:0] v [4];
    wire  signed [15:0] od0, od1, od2, od3;
    wire                ov0, ov1, ov2, ov3;
    wire                fd0, fd1, fd2, fd3;

    int MPV [4] = '{0, 1, 1, 1};
    int WV  [4] = '{4, 4, 5, 6};
    int HV  [4] = '{1, 2, 3, 4};

    int n_cmp = 0;
    int n_fail = 0;
    int last_out [4];
    int got [$];
    int fd_count;

    relu_maxpool_stage #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(1), .MAX_POOL(0)) u0 (
        .clk(clk), .rst(rst), .relu_en_relu(s[0]), .bn_output_relu(v[0]),
        .out_data(od0), .out_valid(ov0), .frame_done(fd0));
    relu_maxpool_stage #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(2), .MAX_POOL(1)) u1 (
        .clk(clk), .rst(rst), .relu_en_relu(s[1]), .bn_output_relu(v[1]),
        .out_data(od1), .out_valid(ov1), .frame_done(fd1));
    relu_maxpool_stage #(.DATA_WIDTH(16), .IMAGE_WIDTH(5), .IMAGE_HEIGHT(3), .MAX_POOL(1)) u2 (
        .clk(clk), .rst(rst), .relu_en_relu(s[2]), .bn_output_relu(v[2]),
        .out_data(od2), .out_valid(ov2), .frame_done(fd2));
    relu_maxpool_stage #(.DATA_WIDTH(16), .IMAGE_WIDTH(6), .IMAGE_HEIGHT(4), .MAX_POOL(1)) u3 (
        .clk(clk), .rst(rst), .relu_en_relu(s[3]), .bn_output_relu(v[3]),
        .out_data(od3), .out_valid(ov3), .frame_done(fd3));

    function automatic int relu(input int x);
        return (x < 0) ? 0 : x;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic sample(input int d, output int o, output int vv, output int ff);
        case (d)
            0: begin o = int'(od0); vv = int'(ov0); ff = int'(fd0); end
            1: begin o = int'(od1); vv = int'(ov1); ff = int'(fd1); end
            2: begin o = int'(od2); vv = int'(ov2); ff = int'(fd2); end
            default: begin o = int'(od3); vv = int'(ov3); ff = int'(fd3); end
        endcase
    endtask

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock on DUT d; outputs sampled on the following falling edge.
    task automatic step(input int d, input logic st, input int val,
                        input int ev, input int ed, input int ef, input string tag);
        int o, vv, ff;
        s[d] = st;
        v[d] = 16'(val);
        @(posedge clk);
        @(negedge clk);
        s[d] = 1'b0;
        sample(d, o, vv, ff);
        check({tag, "_valid"}, vv, ev);
        check({tag, "_fdone"}, ff, ef);
        if (ev != 0) last_out[d] = ed;
        check({tag, "_data"}, o, last_out[d]);
        if (vv != 0 && ev != 0) got.push_back(o);
        if (ff != 0) fd_count++;
    endtask

    // gap: 0 = continuous, 1 = bubble before every pixel, 2 = random 0..3 bubbles
    task automatic send_frame(input int d, input int f [$], input int gap);
        int w, h, r, c, ev, ed, ef, nb;
        w = WV[d];
        h = HV[d];
        for (int k = 0; k < w * h; k++) begin
            nb = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int b = 0; b < nb; b++)
                step(d, 1'b0, int'($urandom), 0, 0, 0, "bubble");
            r = k / w;
            c = k % w;
            ef = (k == w * h - 1) ? 1 : 0;
            if (MPV[d] == 0) begin
                ev = 1;
                ed = relu(f[k]);
            end else if ((r % 2 == 1) && (c % 2 == 1)) begin
                ev = 1;
                ed = max2(max2(relu(f[(r-1)*w + c-1]), relu(f[(r-1)*w + c])),
                          max2(relu(f[r*w + c-1]), relu(f[k])));
            end else begin
                ev = 0;
                ed = 0;
            end
            step(d, 1'b1, f[k], ev, ed, ef, "px");
        end
    endtask

    task automatic do_reset(input int d, input int val);
        int o, vv, ff;
        rst = 1'b1;
        if (d >= 0) begin
            s[d] = 1'b1;
            v[d] = 16'(val);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s[i] = 1'b0;
            sample(i, o, vv, ff);
            check("rst_valid", vv, 0);
            check("rst_fdone", ff, 0);
            check("rst_data", o, 0);
            last_out[i] = 0;
        end
    endtask

    task automatic check_got(input string tag, input int exp_q [$]);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check({tag, "_val"}, got[i], exp_q[i]);
    endtask

    initial begin
        int fa [$];
        int fneg [$];
        int fr [$];
        int ex [$];
        logic signed [15:0] t;

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s[i] = 1'b0;
            v[i] = '0;
            last_out[i] = 0;
        end
        @(negedge clk);
        do_reset(-1, 0);

        // Pass-through ReLU, including the most negative code.
        got.delete(); fd_count = 0;
        fr = '{-5, 7, -32768, 0};
        send_frame(0, fr, 0);
        ex = '{0, 7, 0, 0};
        check_got("relu_pass", ex);
        check("relu_pass_fd", fd_count, 1);

        // 2x2 pooling, continuous.
        fa = '{1, 2, 3, 4, 5, -6, 7, 8};
        ex = '{5, 8};
        got.delete(); fd_count = 0;
        send_frame(1, fa, 0);
        check_got("pool_cont", ex);
        check("pool_cont_fd", fd_count, 1);

        // Same frame with bubbles.
        got.delete(); fd_count = 0;
        send_frame(1, fa, 1);
        check_got("pool_alt", ex);
        got.delete();
        send_frame(1, fa, 2);
        check_got("pool_rgap", ex);
        check("pool_gap_fd", fd_count, 2);

        // Back-to-back frames, second all negative.
        fneg = '{-1, -2, -3, -4, -5, -6, -7, -32768};
        got.delete(); fd_count = 0;
        send_frame(1, fa, 0);
        send_frame(1, fneg, 0);
        ex = '{5, 8, 0, 0};
        check_got("b2b", ex);
        check("b2b_fd", fd_count, 2);

        // Abort after 3 pixels; reset also carries a strobe that must be dropped.
        got.delete(); fd_count = 0;
        for (int k = 0; k < 3; k++)
            step(1, 1'b1, 100 + k, 0, 0, 0, "abort");
        do_reset(1, 1000);
        send_frame(1, fa, 0);
        ex = '{5, 8};
        check_got("abort", ex);
        check("abort_fd", fd_count, 1);

        // Odd width and height: trailing column and row ignored.
        got.delete(); fd_count = 0;
        fr = '{9, 1, 1, 1, 50, 1, 1, 1, 2, 60, 70, 80, 90, 100, 110};
        send_frame(2, fr, 0);
        ex = '{9, 2};
        check_got("odd", ex);
        check("odd_fd", fd_count, 1);

        // Randomized frames against the model.
        for (int n = 0; n < 6; n++) begin
            fr.delete();
            for (int k = 0; k < 24; k++) begin
                t = 16'($urandom);
                fr.push_back(int'(t));
            end
            send_frame(3, fr, (n % 2 == 0) ? 0 : 2);
        end
        for (int n = 0; n < 4; n++) begin
            fr.delete();
            for (int k = 0; k < 4; k++) begin
                t = 16'($urandom);
                fr.push_back(int'(t));
            end
            send_frame(0, fr, n % 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
